// File: rtl/clk_div_pkg.sv
// Shared types, constants and helpers for the clock-divider control stage.
package clk_div_pkg;

  // Control FSM states.
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RUN    = 3'd1,
    ST_STOP   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SETTLE = 3'd4
  } state_e;

  // Ratios 0 and 1 cannot be produced by the divider.
  localparam int unsigned MIN_DIV_RATIO = 2;

  // Width of a counter that must hold values up to 'cycles'.
  function automatic int unsigned settle_cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/clk_div_settle_cnt.sv
// Settle down-counter: load with N-1, count to zero, flag terminal count.
module clk_div_settle_cnt
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = settle_cnt_width(4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tc_q;
  logic             tc_d;

  // Next count: clear wins over load; otherwise decrement and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    tc_d = (cnt_d == '0);
  end

  // Count and registered terminal-count flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider control: accepts ratio requests and applies them as
// stop -> settle -> load -> settle -> restart so the ratio never moves while enabled.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_RATIO_WIDTH = 4,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEFAULT_RATIO   = 2
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  input  logic                       i_req_valid,
  input  logic [DIV_RATIO_WIDTH-1:0] i_req_ratio,
  output logic                       o_req_ready,
  output logic                       o_req_err,
  output logic                       o_done,
  output logic                       o_busy,
  output logic [DIV_RATIO_WIDTH-1:0] o_div_ratio,
  output logic                       o_clk_en
);

  localparam int unsigned CNT_W = settle_cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DIV_RATIO_WIDTH-1:0] RATIO_RST = DIV_RATIO_WIDTH'(DEFAULT_RATIO);
  localparam logic [DIV_RATIO_WIDTH-1:0] RATIO_MIN = DIV_RATIO_WIDTH'(MIN_DIV_RATIO);

  state_e                     state_q,   state_d;
  logic [DIV_RATIO_WIDTH-1:0] ratio_q,   ratio_d;
  logic [DIV_RATIO_WIDTH-1:0] pend_q,    pend_d;
  logic                       restart_q, restart_d;
  logic                       loaded_q,  loaded_d;
  logic                       done_q,    done_d;
  logic                       err_q,     err_d;
  logic                       clk_en_q,  clk_en_d;

  logic req_ready;
  logic xfer;
  logic req_legal;
  logic cnt_load;
  logic cnt_clear;
  logic cnt_tc;

  // Handshake is decoded from the state register only.
  assign req_ready = (state_q == ST_OFF) || (state_q == ST_RUN);
  assign xfer      = i_req_valid && req_ready;
  assign req_legal = (i_req_ratio >= RATIO_MIN);

  // Shared settle counter for STOP and SETTLE.
  clk_div_settle_cnt #(
    .CNT_W (CNT_W)
  ) u_settle_cnt (
    .clk        (i_ref_clk),
    .rst_n      (i_rst_n),
    .clear_i    (cnt_clear),
    .load_i     (cnt_load),
    .load_val_i (CNT_LOAD),
    .tc_o       (cnt_tc)
  );

  // Next-state and registered-output decisions.
  always_comb begin
    state_d   = state_q;
    ratio_d   = ratio_q;
    pend_d    = pend_q;
    restart_d = restart_q;
    loaded_d  = loaded_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        // Divider is stopped, so a legal ratio can be loaded directly.
        if (xfer) begin
          if (req_legal) begin
            ratio_d = i_req_ratio;
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (i_enable) begin
          state_d   = ST_SETTLE;
          restart_d = 1'b1;
          loaded_d  = 1'b0;
          cnt_load  = 1'b1;
        end
      end

      ST_RUN: begin
        // A transfer takes priority over dropping the enable.
        if (xfer) begin
          if (!req_legal) begin
            err_d = 1'b1;
          end else if (i_req_ratio != ratio_q) begin
            pend_d    = i_req_ratio;
            restart_d = 1'b1;
            loaded_d  = 1'b0;
            state_d   = ST_STOP;
            cnt_load  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else if (!i_enable) begin
          state_d   = ST_OFF;
          cnt_clear = 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_tc) begin
          state_d   = ST_LOAD;
          cnt_clear = 1'b1;
        end
      end

      ST_LOAD: begin
        ratio_d  = pend_q;
        loaded_d = 1'b1;
        state_d  = ST_SETTLE;
        cnt_load = 1'b1;
      end

      ST_SETTLE: begin
        // Enable is only sampled here, at the end of the sequence.
        if (cnt_tc) begin
          done_d    = loaded_q;
          loaded_d  = 1'b0;
          restart_d = 1'b0;
          cnt_clear = 1'b1;
          state_d   = (restart_q && i_enable) ? ST_RUN : ST_OFF;
        end
      end

      default: begin
        state_d   = ST_OFF;
        cnt_clear = 1'b1;
      end
    endcase

    clk_en_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_OFF;
      ratio_q   <= RATIO_RST;
      pend_q    <= RATIO_RST;
      restart_q <= 1'b0;
      loaded_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ratio_q   <= ratio_d;
      pend_q    <= pend_d;
      restart_q <= restart_d;
      loaded_q  <= loaded_d;
      done_q    <= done_d;
      err_q     <= err_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign o_req_ready = req_ready;
  assign o_busy      = (state_q == ST_STOP) || (state_q == ST_LOAD) || (state_q == ST_SETTLE);
  assign o_req_err   = err_q;
  assign o_done      = done_q;
  assign o_div_ratio = ratio_q;
  assign o_clk_en    = clk_en_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a timeline model.
module tb_clk_div_ctrl;

  localparam int S   = 4;
  localparam int DEF = 2;

  logic       i_ref_clk;
  logic       i_rst_n;
  logic       i_enable;
  logic       i_req_valid;
  logic [3:0] i_req_ratio;
  logic       o_req_ready;
  logic       o_req_err;
  logic       o_done;
  logic       o_busy;
  logic [3:0] o_div_ratio;
  logic       o_clk_en;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_on = 0;

  // Model: a busy sequence is a countdown; the ratio lands at a fixed offset.
  int m_ratio, m_pend, m_busy_left, m_load_at;
  bit m_en, m_done, m_err, m_run, m_loaded, m_xfer;

  clk_div_ctrl #(
    .DIV_RATIO_WIDTH (4),
    .SETTLE_CYCLES   (S),
    .DEFAULT_RATIO   (DEF)
  ) dut (
    .i_ref_clk   (i_ref_clk),
    .i_rst_n     (i_rst_n),
    .i_enable    (i_enable),
    .i_req_valid (i_req_valid),
    .i_req_ratio (i_req_ratio),
    .o_req_ready (o_req_ready),
    .o_req_err   (o_req_err),
    .o_done      (o_done),
    .o_busy      (o_busy),
    .o_div_ratio (o_div_ratio),
    .o_clk_en    (o_clk_en)
  );

  initial i_ref_clk = 1'b0;
  always #5 i_ref_clk = ~i_ref_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge i_ref_clk);
  endtask

  always @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_ratio = DEF; m_pend = DEF; m_busy_left = 0; m_load_at = 0;
      m_en = 0; m_done = 0; m_err = 0; m_run = 0; m_loaded = 0; m_xfer = 0;
    end else begin
      m_done = 0; m_err = 0; m_xfer = 0;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_load_at > 0) begin
          m_load_at--;
          if (m_load_at == 0) begin
            m_ratio  = m_pend;
            m_loaded = 1;
          end
        end
        if (m_busy_left == 0) begin
          m_run    = i_enable;
          m_done   = m_loaded;
          m_loaded = 0;
        end
      end else begin
        if (i_req_valid) begin
          m_xfer = 1;
          if (int'(i_req_ratio) < 2) m_err = 1;
          else if (!m_run) begin
            m_ratio = int'(i_req_ratio);
            m_done  = 1;
          end else if (int'(i_req_ratio) != m_ratio) begin
            m_pend      = int'(i_req_ratio);
            m_busy_left = 2 * S + 1;
            m_load_at   = S + 1;
          end else m_done = 1;
        end
        if (!m_run && i_enable) m_busy_left = S;
        else if (m_run && !i_req_valid && !i_enable) m_run = 0;
      end
      m_en = m_run && (m_busy_left == 0);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge i_ref_clk) begin
    if (cmp_on) begin
      chk("clk_en",    int'(o_clk_en),    int'(m_en));
      chk("div_ratio", int'(o_div_ratio), m_ratio);
      chk("done",      int'(o_done),      int'(m_done));
      chk("req_err",   int'(o_req_err),   int'(m_err));
      chk("busy",      int'(o_busy),      int'(m_busy_left > 0));
      chk("req_ready", int'(o_req_ready), int'(m_busy_left == 0));
    end
  end

  initial begin
    int r;
    i_rst_n = 1'b1; i_enable = 1'b0; i_req_valid = 1'b0; i_req_ratio = 4'd0;
    #1 i_rst_n = 1'b0;
    cmp_on = 1;
    repeat (3) tick();
    chk("rst_ratio", int'(o_div_ratio), 2);
    chk("rst_clk_en", int'(o_clk_en), 0);
    chk("rst_ready", int'(o_req_ready), 1);
    chk("rst_busy", int'(o_busy), 0);
    i_rst_n = 1'b1;

    // Enable from OFF: clock enable returns S+1 cycles later, no done.
    tick(); tick();
    i_enable = 1'b1;
    repeat (S) tick();
    chk("t1_en_low", int'(o_clk_en), 0);
    tick();
    chk("t1_en_high", int'(o_clk_en), 1);
    chk("t1_ratio", int'(o_div_ratio), 2);
    chk("t1_done", int'(o_done), 0);

    // Ratio change in RUN.
    i_req_valid = 1'b1; i_req_ratio = 4'd6;
    tick();
    i_req_valid = 1'b0;
    chk("t2_en_drop", int'(o_clk_en), 0);
    chk("t2_busy", int'(o_busy), 1);
    repeat (4) tick();
    chk("t2_ratio_old", int'(o_div_ratio), 2);
    tick();
    chk("t2_ratio_new", int'(o_div_ratio), 6);
    repeat (3) tick();
    chk("t2_en_still_low", int'(o_clk_en), 0);
    tick();
    chk("t2_en_back", int'(o_clk_en), 1);
    chk("t2_done", int'(o_done), 1);
    tick();
    chk("t2_done_pulse", int'(o_done), 0);

    // Illegal ratios 1 and 0.
    i_req_valid = 1'b1; i_req_ratio = 4'd1;
    tick();
    i_req_valid = 1'b0;
    chk("t3_err1", int'(o_req_err), 1);
    chk("t3_ratio1", int'(o_div_ratio), 6);
    chk("t3_en1", int'(o_clk_en), 1);
    tick();
    chk("t3_err_pulse", int'(o_req_err), 0);
    i_req_valid = 1'b1; i_req_ratio = 4'd0;
    tick();
    i_req_valid = 1'b0;
    chk("t3_err0", int'(o_req_err), 1);
    chk("t3_ratio0", int'(o_div_ratio), 6);
    chk("t3_done0", int'(o_done), 0);

    // Load directly in OFF.
    i_enable = 1'b0;
    tick();
    chk("t4_off", int'(o_clk_en), 0);
    i_req_valid = 1'b1; i_req_ratio = 4'd9;
    tick();
    i_req_valid = 1'b0;
    chk("t4_ratio", int'(o_div_ratio), 9);
    chk("t4_done", int'(o_done), 1);
    chk("t4_en", int'(o_clk_en), 0);

    // Request and enable drop together: full sequence then OFF.
    i_enable = 1'b1;
    repeat (S + 1) tick();
    chk("t5_run", int'(o_clk_en), 1);
    i_req_valid = 1'b1; i_req_ratio = 4'd5; i_enable = 1'b0;
    tick();
    i_req_valid = 1'b0;
    repeat (2 * S + 1) tick();
    chk("t5_ratio", int'(o_div_ratio), 5);
    chk("t5_done", int'(o_done), 1);
    chk("t5_en", int'(o_clk_en), 0);
    chk("t5_ready", int'(o_req_ready), 1);

    // Asynchronous reset while in LOAD.
    i_enable = 1'b1;
    repeat (S + 1) tick();
    i_req_valid = 1'b1; i_req_ratio = 4'd7;
    tick();
    i_req_valid = 1'b0;
    repeat (S) tick();
    chk("t6_in_load", int'(o_busy), 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6_ratio", int'(o_div_ratio), 2);
    chk("t6_en", int'(o_clk_en), 0);
    chk("t6_ready", int'(o_req_ready), 1);
    chk("t6_busy", int'(o_busy), 0);
    chk("t6_done", int'(o_done), 0);
    tick();
    i_rst_n = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!i_req_valid || m_xfer) begin
        if ($urandom_range(0, 3) == 0) begin
          i_req_valid = 1'b1;
          r = int'($urandom_range(0, 15));
          if ($urandom_range(0, 7) == 0) r = m_ratio;
          i_req_ratio = 4'(r);
        end else begin
          i_req_valid = 1'b0;
        end
      end
      if ($urandom_range(0, 15) == 0) i_enable = ~i_enable;
      if ($urandom_range(0, 499) == 0) begin
        #2 i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
      end
    end

    tick();
    cmp_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
